// File: rtl/tl_pkg.sv
// ============================================================================
// Module : tl_pkg
// Brief  : Shared TileLink-UL opcode constants and size-to-beat conversion.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package tl_pkg;

    localparam logic [2:0] c_tl_a_put_full_data    = 3'd0;
    localparam logic [2:0] c_tl_a_put_partial_data = 3'd1;
    localparam logic [2:0] c_tl_a_get              = 3'd4;

    localparam logic [2:0] c_tl_d_access_ack       = 3'd0;
    localparam logic [2:0] c_tl_d_access_ack_data  = 3'd1;

    // A transfer smaller than one bus word still occupies a single beat.
    function automatic logic [31:0] size_to_beats(input logic [7:0] size,
                                                  input logic [7:0] lg_bytes);
        if (size <= lg_bytes) begin
            return 32'd1;
        end
        return 32'd1 << (size - lg_bytes);
    endfunction

endpackage

`default_nettype wire

// File: rtl/tl_sram_array.sv
// ============================================================================
// Module : tl_sram_array
// Brief  : Single-port word RAM, one-cycle read latency, byte write enables.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tl_sram_array #(
    parameter int DW    = 32,
    parameter int DEPTH = 1024
) (
    input  logic                     clk,
    input  logic                     i_en,
    input  logic                     i_we,
    input  logic [DW/8-1:0]          i_be,
    input  logic [$clog2(DEPTH)-1:0] i_addr,
    input  logic [DW-1:0]            i_wdata,
    output logic [DW-1:0]            o_rdata
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_rdata;

    // Read data holds its value until the next read, so callers may leave it parked.
    always_ff @(posedge clk) begin
        if (i_en && i_we) begin
            for (int b = 0; b < DW/8; b++) begin
                if (i_be[b]) begin
                    r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end else if (i_en) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/tilelink_sram_slave.sv
// ============================================================================
// Module : tilelink_sram_slave
// Brief  : TileLink-UL SRAM slave (Get / PutFull / PutPartial, bursts).
//          Define TL_SRAM_RANGE_CHECK_EN to deny beats beyond DEPTH_WORDS.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tilelink_sram_slave
    import tl_pkg::*;
#(
    parameter int TL_DW       = 32,
    parameter int TL_AW       = 32,
    parameter int TL_SZ       = 4,
    parameter int TL_SID      = 5,
    parameter int DEPTH_WORDS = 1024
) (
    input  logic                tilelink_clock_i,
    input  logic                tilelink_reset_i,

    input  logic [2:0]          a_opcode,
    input  logic [2:0]          a_param,
    input  logic [TL_SZ-1:0]    a_size,
    input  logic [TL_SID-1:0]   a_source,
    input  logic [TL_AW-1:0]    a_address,
    input  logic [TL_DW/8-1:0]  a_mask,
    input  logic [TL_DW-1:0]    a_data,
    input  logic                a_corrupt,
    input  logic                a_valid,
    output logic                a_ready,

    output logic [2:0]          d_opcode,
    output logic [1:0]          d_param,
    output logic [TL_SZ-1:0]    d_size,
    output logic [TL_SID-1:0]   d_source,
    output logic                d_denied,
    output logic [TL_DW-1:0]    d_data,
    output logic                d_corrupt,
    output logic                d_valid,
    input  logic                d_ready
);

    localparam int c_lg_bytes = $clog2(TL_DW/8);
    localparam int c_mem_aw   = $clog2(DEPTH_WORDS);
    localparam int c_cnt_w    = (TL_SZ >= 5) ? 32 : (1 << TL_SZ);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PUT  = 2'd1,
        S_ACK  = 2'd2,
        S_GET  = 2'd3
    } state_t;

    state_t               r_state;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [c_cnt_w-1:0]   r_out_cnt;
    logic [TL_AW-1:0]     r_word;
    logic                 r_rd_pend;
    logic                 r_rd_oob;

    logic [2:0]           r_d_opcode;
    logic [TL_SZ-1:0]     r_d_size;
    logic [TL_SID-1:0]    r_d_source;
    logic                 r_d_denied;
    logic [TL_DW-1:0]     r_d_data;
    logic                 r_d_corrupt;
    logic                 r_d_valid;

    logic                 w_a_ready;
    logic                 w_a_fire;
    logic                 w_is_put_op;
    logic                 w_is_put_beat;
    logic [31:0]          w_beats_full;
    logic [c_cnt_w-1:0]   w_beats;
    logic [TL_AW-1:0]     w_base;
    logic [TL_AW-1:0]     w_word;
    logic                 w_oob;
    logic                 w_out_free;
    logic                 w_issue;
    logic                 w_mem_en;
    logic                 w_mem_we;
    logic [TL_DW-1:0]     w_mem_rdata;
    logic                 w_unused;

    assign w_a_ready     = (r_state == S_IDLE) || (r_state == S_PUT);
    assign w_a_fire      = a_valid && w_a_ready && !tilelink_reset_i;
    assign w_is_put_op   = (a_opcode == c_tl_a_put_full_data) ||
                           (a_opcode == c_tl_a_put_partial_data);
    assign w_is_put_beat = w_a_fire &&
                           ((r_state == S_PUT) || ((r_state == S_IDLE) && w_is_put_op));
    assign w_beats_full  = size_to_beats(8'(a_size), 8'(c_lg_bytes));
    assign w_beats       = w_beats_full[c_cnt_w-1:0];
    assign w_base        = a_address >> c_lg_bytes;
    assign w_word        = (r_state == S_IDLE) ? w_base : r_word;

`ifdef TL_SRAM_RANGE_CHECK_EN
    assign w_oob = (w_word >= TL_AW'(DEPTH_WORDS));
`else
    assign w_oob = 1'b0;
`endif

    // A new read may only be issued if the previous read result has somewhere to go.
    assign w_out_free = !r_d_valid || d_ready;
    assign w_issue    = (r_state == S_GET) && (r_cnt != '0) && (!r_rd_pend || w_out_free);
    assign w_mem_we   = w_is_put_beat && !a_corrupt && !w_oob;
    assign w_mem_en   = w_mem_we || w_issue;

    tl_sram_array #(
        .DW    (TL_DW),
        .DEPTH (DEPTH_WORDS)
    ) u_sram (
        .clk     (tilelink_clock_i),
        .i_en    (w_mem_en),
        .i_we    (w_mem_we),
        .i_be    (a_mask),
        .i_addr  (w_word[c_mem_aw-1:0]),
        .i_wdata (a_data),
        .o_rdata (w_mem_rdata)
    );

    always_ff @(posedge tilelink_clock_i) begin
        if (tilelink_reset_i) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_out_cnt   <= '0;
            r_word      <= '0;
            r_rd_pend   <= 1'b0;
            r_rd_oob    <= 1'b0;
            r_d_opcode  <= '0;
            r_d_size    <= '0;
            r_d_source  <= '0;
            r_d_denied  <= 1'b0;
            r_d_data    <= '0;
            r_d_corrupt <= 1'b0;
            r_d_valid   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_a_fire) begin
                        r_d_size    <= a_size;
                        r_d_source  <= a_source;
                        r_d_data    <= '0;
                        r_d_corrupt <= 1'b0;
                        if (a_opcode == c_tl_a_get) begin
                            r_state    <= S_GET;
                            r_cnt      <= w_beats;
                            r_out_cnt  <= w_beats;
                            r_word     <= w_base;
                            r_rd_pend  <= 1'b0;
                            r_d_opcode <= c_tl_d_access_ack_data;
                            r_d_denied <= 1'b0;
                        end else if (w_is_put_op) begin
                            r_d_opcode <= c_tl_d_access_ack;
                            r_d_denied <= w_oob;
                            r_word     <= w_base + TL_AW'(1);
                            if (w_beats > c_cnt_w'(1)) begin
                                r_state <= S_PUT;
                                r_cnt   <= w_beats - c_cnt_w'(1);
                            end else begin
                                r_state   <= S_ACK;
                                r_cnt     <= '0;
                                r_d_valid <= 1'b1;
                            end
                        end else begin
                            r_state    <= S_ACK;
                            r_d_opcode <= c_tl_d_access_ack;
                            r_d_denied <= 1'b1;
                            r_d_valid  <= 1'b1;
                        end
                    end
                end

                S_PUT: begin
                    if (w_a_fire) begin
                        r_d_denied <= r_d_denied | w_oob;
                        r_word     <= r_word + TL_AW'(1);
                        r_cnt      <= r_cnt - c_cnt_w'(1);
                        if (r_cnt == c_cnt_w'(1)) begin
                            r_state   <= S_ACK;
                            r_d_valid <= 1'b1;
                        end
                    end
                end

                S_ACK: begin
                    if (d_ready) begin
                        r_state   <= S_IDLE;
                        r_d_valid <= 1'b0;
                    end
                end

                S_GET: begin
                    if (w_issue) begin
                        r_cnt    <= r_cnt - c_cnt_w'(1);
                        r_word   <= r_word + TL_AW'(1);
                        r_rd_oob <= w_oob;
                    end
                    r_rd_pend <= w_issue || (r_rd_pend && !w_out_free);
                    if (w_out_free) begin
                        if (r_rd_pend) begin
                            r_d_valid   <= 1'b1;
                            r_d_data    <= r_rd_oob ? '0 : w_mem_rdata;
                            r_d_corrupt <= r_rd_oob;
                            r_d_denied  <= r_rd_oob;
                        end else begin
                            r_d_valid   <= 1'b0;
                        end
                    end
                    if (r_d_valid && d_ready) begin
                        r_out_cnt <= r_out_cnt - c_cnt_w'(1);
                        if (r_out_cnt == c_cnt_w'(1)) begin
                            r_state <= S_IDLE;
                        end
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign a_ready   = w_a_ready;
    assign d_opcode  = r_d_opcode;
    assign d_param   = 2'd0;
    assign d_size    = r_d_size;
    assign d_source  = r_d_source;
    assign d_denied  = r_d_denied;
    assign d_data    = r_d_data;
    assign d_corrupt = r_d_corrupt;
    assign d_valid   = r_d_valid;

    assign w_unused = ^{a_param, w_beats_full, w_word, a_address};

endmodule

`default_nettype wire

// File: tb/tb_tilelink_sram_slave.sv
// ============================================================================
// Module : tb_tilelink_sram_slave
// Brief  : Directed self-checking bench for tilelink_sram_slave (TL_DW=32).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_tilelink_sram_slave;
    import tl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [3:0]  a_size;
    logic [4:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        a_corrupt;
    logic        a_valid;
    logic        a_ready;
    logic [2:0]  d_opcode;
    logic [1:0]  d_param;
    logic [3:0]  d_size;
    logic [4:0]  d_source;
    logic        d_denied;
    logic [31:0] d_data;
    logic        d_corrupt;
    logic        d_valid;
    logic        d_ready;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_words [8];

    always #5 clk = ~clk;

    tilelink_sram_slave #(
        .TL_DW(32), .TL_AW(32), .TL_SZ(4), .TL_SID(5), .DEPTH_WORDS(1024)
    ) dut (
        .tilelink_clock_i (clk),
        .tilelink_reset_i (rst),
        .a_opcode  (a_opcode),
        .a_param   (a_param),
        .a_size    (a_size),
        .a_source  (a_source),
        .a_address (a_address),
        .a_mask    (a_mask),
        .a_data    (a_data),
        .a_corrupt (a_corrupt),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .d_opcode  (d_opcode),
        .d_param   (d_param),
        .d_size    (d_size),
        .d_source  (d_source),
        .d_denied  (d_denied),
        .d_data    (d_data),
        .d_corrupt (d_corrupt),
        .d_valid   (d_valid),
        .d_ready   (d_ready)
    );

    task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_beat(input logic [2:0] op, input logic [3:0] size, input logic [4:0] src,
                          input logic [31:0] addr, input logic [3:0] mask,
                          input logic [31:0] data, input logic corrupt);
        int w = 0;
        a_opcode  = op;
        a_size    = size;
        a_source  = src;
        a_address = addr;
        a_mask    = mask;
        a_data    = data;
        a_corrupt = corrupt;
        a_valid   = 1'b1;
        while (!a_ready && w < 20) begin
            tick();
            w++;
        end
        check_value("a_ready", a_ready, 1);
        tick();
        a_valid = 1'b0;
    endtask

    task automatic wait_ack(input string tag, input logic [4:0] src, input logic [3:0] size,
                            input logic den);
        int w = 0;
        while (!d_valid && w < 20) begin
            tick();
            w++;
        end
        check_value({tag, "_valid"},   d_valid,   1);
        check_value({tag, "_opcode"},  d_opcode,  c_tl_d_access_ack);
        check_value({tag, "_source"},  d_source,  src);
        check_value({tag, "_size"},    d_size,    size);
        check_value({tag, "_denied"},  d_denied,  den);
        check_value({tag, "_data"},    d_data,    0);
        check_value({tag, "_corrupt"}, d_corrupt, 0);
        check_value({tag, "_param"},   d_param,   0);
        check_value({tag, "_aready"},  a_ready,   0);
        tick();
        check_value({tag, "_single"},  d_valid,   0);
    endtask

    // Later beats carry scrambled size/source/address, which the slave must ignore.
    task automatic do_put(input string tag, input logic [2:0] op, input logic [3:0] size,
                          input logic [4:0] src, input logic [31:0] addr, input logic [3:0] mask,
                          input int nbeats, input logic den);
        for (int k = 0; k < nbeats; k++) begin
            if (k == 0) a_beat(op, size, src, addr, mask, exp_words[k], 1'b0);
            else        a_beat(op, size ^ 4'h1, src ^ 5'h1, addr ^ 32'h0000_0FF0, mask,
                               exp_words[k], 1'b0);
            if (k < nbeats - 1) check_value({tag, "_early_ack"}, d_valid, 0);
        end
        wait_ack(tag, src, size, den);
    endtask

    task automatic do_get(input string tag, input logic [3:0] size, input logic [4:0] src,
                          input logic [31:0] addr, input int nbeats, input int stall_beat,
                          input logic den, input logic cor);
        int          lat = 0;
        logic [31:0] held;
        a_beat(c_tl_a_get, size, src, addr, 4'hF, 32'h0, 1'b0);
        while (!d_valid && lat < 20) begin
            tick();
            lat++;
        end
        check_value({tag, "_latency"}, lat, 2);
        for (int k = 0; k < nbeats; k++) begin
            check_value({tag, "_bvalid"},  d_valid,   1);
            check_value({tag, "_bdata"},   d_data,    exp_words[k]);
            check_value({tag, "_bopcode"}, d_opcode,  c_tl_d_access_ack_data);
            check_value({tag, "_bsource"}, d_source,  src);
            check_value({tag, "_bsize"},   d_size,    size);
            check_value({tag, "_bdenied"}, d_denied,  den);
            check_value({tag, "_bcorr"},   d_corrupt, cor);
            if (k == stall_beat) begin
                held    = d_data;
                d_ready = 1'b0;
                repeat (3) begin
                    tick();
                    check_value({tag, "_hold_valid"}, d_valid, 1);
                    check_value({tag, "_hold_data"},  d_data,  held);
                end
                d_ready = 1'b1;
            end
            tick();
        end
        check_value({tag, "_end_valid"}, d_valid, 0);
        check_value({tag, "_end_aready"}, a_ready, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        a_valid   = 1'b0;
        a_opcode  = '0;
        a_param   = '0;
        a_size    = '0;
        a_source  = '0;
        a_address = '0;
        a_mask    = '0;
        a_data    = '0;
        a_corrupt = 1'b0;
        d_ready   = 1'b1;
        repeat (3) tick();
        check_value("rst_dvalid",  d_valid,   0);
        check_value("rst_aready",  a_ready,   1);
        check_value("rst_opcode",  d_opcode,  0);
        check_value("rst_data",    d_data,    0);
        check_value("rst_size",    d_size,    0);
        check_value("rst_source",  d_source,  0);
        check_value("rst_denied",  d_denied,  0);
        check_value("rst_corrupt", d_corrupt, 0);
        rst = 1'b0;
        tick();

        exp_words[0] = 32'hDEAD_BEEF;
        do_put("put1", c_tl_a_put_full_data, 4'd2, 5'd5, 32'h10, 4'hF, 1, 1'b0);
        do_get("get1", 4'd2, 5'd3, 32'h10, 1, -1, 1'b0, 1'b0);

        // A corrupt beat must be acknowledged but leave memory untouched.
        a_beat(c_tl_a_put_full_data, 4'd2, 5'd6, 32'h10, 4'hF, 32'h0BAD_0BAD, 1'b1);
        wait_ack("putcorr", 5'd6, 4'd2, 1'b0);
        do_get("getcorr", 4'd2, 5'd6, 32'h10, 1, -1, 1'b0, 1'b0);

        a_beat(3'd2, 4'd2, 5'd7, 32'h20, 4'hF, 32'h1, 1'b0);
        wait_ack("unsup", 5'd7, 4'd2, 1'b1);

        exp_words[0] = 32'd1; exp_words[1] = 32'd2; exp_words[2] = 32'd3; exp_words[3] = 32'd4;
        do_put("burst_put", c_tl_a_put_full_data, 4'd4, 5'd9, 32'h40, 4'hF, 4, 1'b0);
        do_get("burst_get", 4'd4, 5'd10, 32'h40, 4, -1, 1'b0, 1'b0);

        exp_words[0] = 32'h1122_3344;
        do_put("pp_base", c_tl_a_put_full_data, 4'd2, 5'd1, 32'h80, 4'hF, 1, 1'b0);
        exp_words[0] = 32'hAABB_CCDD;
        do_put("pp_part", c_tl_a_put_partial_data, 4'd2, 5'd1, 32'h80, 4'b0101, 1, 1'b0);
        exp_words[0] = 32'h11BB_33DD;
        do_get("pp_get", 4'd2, 5'd1, 32'h80, 1, -1, 1'b0, 1'b0);

        exp_words[0] = 32'd1; exp_words[1] = 32'd2; exp_words[2] = 32'd3; exp_words[3] = 32'd4;
        do_get("stall_get", 4'd4, 5'd11, 32'h40, 4, 1, 1'b0, 1'b0);

        exp_words[0] = 32'hCAFE_0000; exp_words[1] = 32'hCAFE_0001;
        do_put("low_put", c_tl_a_put_full_data, 4'd3, 5'd2, 32'h0, 4'hF, 2, 1'b0);
`ifdef TL_SRAM_RANGE_CHECK_EN
        exp_words[0] = 32'h0; exp_words[1] = 32'h0;
        do_get("range_get", 4'd3, 5'd4, 32'h1000, 2, -1, 1'b1, 1'b1);
`else
        do_get("range_get", 4'd3, 5'd4, 32'h1000, 2, -1, 1'b0, 1'b0);
`endif

        a_beat(c_tl_a_put_full_data, 4'd4, 5'd2, 32'h40, 4'hF, 32'h100, 1'b0);
        a_beat(c_tl_a_put_full_data, 4'd4, 5'd2, 32'h44, 4'hF, 32'h200, 1'b0);
        rst = 1'b1;
        tick();
        check_value("midrst_dvalid", d_valid, 0);
        check_value("midrst_aready", a_ready, 1);
        rst = 1'b0;
        tick();
        check_value("midrst_idle", d_valid, 0);
        exp_words[0] = 32'h100; exp_words[1] = 32'h200; exp_words[2] = 32'd3; exp_words[3] = 32'd4;
        do_get("midrst_get", 4'd4, 5'd12, 32'h40, 4, -1, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
